// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc_pkg
//  Description : Shared definitions for the colour-correction coefficient
//                scheduler: coefficient index map, scheduler FSM states and
//                the identity-matrix initialiser used by the shadow bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    // Row-major index of each coefficient of the 3x4 matrix
    localparam int A11_IDX  = 0;
    localparam int A12_IDX  = 1;
    localparam int A13_IDX  = 2;
    localparam int A14_IDX  = 3;
    localparam int A21_IDX  = 4;
    localparam int A22_IDX  = 5;
    localparam int A23_IDX  = 6;
    localparam int A24_IDX  = 7;
    localparam int A31_IDX  = 8;
    localparam int A32_IDX  = 9;
    localparam int A33_IDX  = 10;
    localparam int A34_IDX  = 11;
    localparam int NUM_COEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOAD  = 2'd2
    } cc_state_e;

    // Identity matrix entry for coefficient idx: 1.0 on the diagonal of the
    // 3x3 part, zero elsewhere (including the offset column).
    function automatic logic [63:0] identity_coef(input int idx, input int fract_width);
        logic [63:0] v;
        v = 64'd0;
        if (idx == A11_IDX || idx == A22_IDX || idx == A33_IDX) begin
            v = 64'd1 << fract_width;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_stream_if
//  Description : AXI4-Stream bundle. tuser carries start-of-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 4
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic                       tuser;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                    input  tready);
    modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                    output tready);
endinterface
`default_nettype wire

// File: rtl/cc_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cc_coef_bank
//  Description : 12-entry CSR shadow register file plus snapshot copy.
//                Ports:
//                  clk_i, rst_i      clock, async active-high reset
//                  wr_i/sel_i/wdata_i shadow write port (index >11 ignored)
//                  rdata_o           registered shadow[sel_i], 0 for >11
//                  snap_i            copy shadow (with same-cycle write) to snapshot
//                  snap_sel_i        snapshot read index
//                  snap_next_o       value snapshot[snap_sel_i] holds after
//                                    the coming clock edge
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_coef_bank
    import cc_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic [3:0]                    sel_i,
    input  logic [PX_WIDTH+FRACT_WIDTH:0] wdata_i,
    output logic [PX_WIDTH+FRACT_WIDTH:0] rdata_o,
    input  logic                          snap_i,
    input  logic [3:0]                    snap_sel_i,
    output logic [PX_WIDTH+FRACT_WIDTH:0] snap_next_o
);
    localparam int CW = PX_WIDTH + FRACT_WIDTH + 1;

    logic [CW-1:0] r_shadow [NUM_COEF];
    logic [CW-1:0] r_snap   [NUM_COEF];
    logic [CW-1:0] r_rdata;
    logic [CW-1:0] w_snap_src [NUM_COEF];
    logic          w_wr_ok;
    logic          w_sel_ok;
    logic          w_snap_sel_ok;

    assign w_wr_ok       = wr_i && (sel_i < 4'(NUM_COEF));
    assign w_sel_ok      = (sel_i < 4'(NUM_COEF));
    assign w_snap_sel_ok = (snap_sel_i < 4'(NUM_COEF));

    // Snapshot source includes a write landing in the same cycle, so a
    // write issued together with commit is part of the captured bank.
    for (genvar g = 0; g < NUM_COEF; g++) begin : g_snap_src
        assign w_snap_src[g] = (w_wr_ok && (sel_i == 4'(g))) ? wdata_i : r_shadow[g];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_shadow[i] <= CW'(identity_coef(i, FRACT_WIDTH));
                r_snap[i]   <= CW'(identity_coef(i, FRACT_WIDTH));
            end
            r_rdata <= '0;
        end else begin
            for (int i = 0; i < NUM_COEF; i++) begin
                if (w_wr_ok && (sel_i == 4'(i))) begin
                    r_shadow[i] <= wdata_i;
                end
                if (snap_i) begin
                    r_snap[i] <= w_snap_src[i];
                end
            end
            r_rdata <= w_sel_ok ? r_shadow[sel_i] : '0;
        end
    end

    assign rdata_o = r_rdata;

    always_comb begin
        snap_next_o = '0;
        if (w_snap_sel_ok) begin
            snap_next_o = snap_i ? w_snap_src[snap_sel_i] : r_snap[snap_sel_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cc_coef_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cc_coef_sched
//  Description : Frame-synchronous coefficient scheduler for the 3x4 colour
//                correction matrix. Commits from the shadow bank are applied
//                at the next start-of-frame beat (or at once on force) by
//                stalling the stream and walking the 12 coefficients into
//                the corrector's coefficient port.
//                Ports:
//                  clk_i, rst_i              clock, async active-high reset
//                  csr_wr_i/sel_i/wdata_i    shadow bank write
//                  csr_rdata_o               registered shadow readback
//                  commit_i, force_i         apply at next SOF / immediately
//                  pending_o, busy_o         status
//                  applied_cnt_o             completed loads (wraps)
//                  cc_coef_sel_o/cc_coef_o/cc_coef_lock_o  corrector port
//                  video_i, video_o          AXI4-Stream in / to corrector
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_coef_sched
    import cc_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          csr_wr_i,
    input  logic [3:0]                    csr_sel_i,
    input  logic [PX_WIDTH+FRACT_WIDTH:0] csr_wdata_i,
    output logic [PX_WIDTH+FRACT_WIDTH:0] csr_rdata_o,
    input  logic                          commit_i,
    input  logic                          force_i,
    output logic                          pending_o,
    output logic                          busy_o,
    output logic [15:0]                   applied_cnt_o,
    output logic [3:0]                    cc_coef_sel_o,
    output logic [PX_WIDTH+FRACT_WIDTH:0] cc_coef_o,
    output logic                          cc_coef_lock_o,
    axi4_stream_if.slave                  video_i,
    axi4_stream_if.master                 video_o
);
    localparam int CW = PX_WIDTH + FRACT_WIDTH + 1;

    cc_state_e         r_state;
    cc_state_e         w_state_next;
    logic [3:0]        r_idx;
    logic [3:0]        w_idx_next;
    logic              r_defer;
    logic              w_defer_next;
    logic              w_snap;
    logic              w_cnt_inc;
    logic              w_any_req;
    logic              w_last;
    logic              w_sof;
    logic              w_stall;
    logic              w_load_next;
    logic [CW-1:0]     w_snap_next;
    logic [15:0]       r_applied_cnt;
    logic              r_lock;
    logic [3:0]        r_sel;
    logic [CW-1:0]     r_coef;
    logic [TDATA_WIDTH-1:0] w_tdata;

    cc_coef_bank #(
        .PX_WIDTH    (PX_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_bank (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_i        (csr_wr_i),
        .sel_i       (csr_sel_i),
        .wdata_i     (csr_wdata_i),
        .rdata_o     (csr_rdata_o),
        .snap_i      (w_snap),
        .snap_sel_i  (w_idx_next),
        .snap_next_o (w_snap_next)
    );

    assign w_any_req = commit_i | force_i;
    assign w_last    = (r_idx == 4'(NUM_COEF - 1));
    assign w_sof     = video_i.tvalid & video_i.tuser;

    // Next-state / control decode
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = '0;
        w_defer_next = r_defer;
        w_snap       = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (force_i) begin
                    w_snap       = 1'b1;
                    w_state_next = ST_LOAD;
                end else if (commit_i) begin
                    w_snap       = 1'b1;
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A new request replaces the armed snapshot (latest wins)
                w_snap = w_any_req;
                if (force_i || w_sof) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_cnt_inc    = 1'b1;
                    w_defer_next = 1'b0;
                    // Deferred request (or one arriving now) re-snapshots on
                    // exit and waits for the next SOF, even if it was a force.
                    if (r_defer || w_any_req) begin
                        w_snap       = 1'b1;
                        w_state_next = ST_ARMED;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_idx_next   = r_idx + 4'd1;
                    w_defer_next = r_defer | w_any_req;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_load_next = (w_state_next == ST_LOAD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_defer       <= 1'b0;
            r_applied_cnt <= '0;
            r_lock        <= 1'b0;
            r_sel         <= '0;
            r_coef        <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_defer <= w_defer_next;
            if (w_cnt_inc) begin
                r_applied_cnt <= r_applied_cnt + 16'd1;
            end
            // Corrector port is registered from next-state values so the
            // lock pulses line up exactly with the 12 LOAD cycles.
            r_lock <= w_load_next;
            r_sel  <= w_load_next ? w_idx_next  : 4'd0;
            r_coef <= w_load_next ? w_snap_next : '0;
        end
    end

    assign cc_coef_lock_o = r_lock;
    assign cc_coef_sel_o  = r_sel;
    assign cc_coef_o      = r_coef;
    assign applied_cnt_o  = r_applied_cnt;
    assign busy_o         = (r_state == ST_LOAD);
    assign pending_o      = (r_state == ST_ARMED) | r_defer;

    // Hold the SOF beat (and everything during LOAD) off the corrector
    assign w_stall        = (r_state == ST_LOAD) | ((r_state == ST_ARMED) & w_sof);
    assign video_o.tvalid = video_i.tvalid & ~w_stall;
    assign video_i.tready = video_o.tready & ~w_stall;

    assign w_tdata        = video_i.tdata;
    assign video_o.tdata  = w_tdata;
    assign video_o.tlast  = video_i.tlast;
    assign video_o.tuser  = video_i.tuser;
    assign video_o.tstrb  = video_i.tstrb;
    assign video_o.tkeep  = video_i.tkeep;
    assign video_o.tid    = video_i.tid;
    assign video_o.tdest  = video_i.tdest;

endmodule
`default_nettype wire
